// File: rtl/fft_reorder_if.sv
// fft_reorder_if: stream bundle between the FFT top, the reorder buffer and
// its consumer.
//   cfg        frame log2 length, sampled with an accepted in_first
//   in_real    bit-reversed-order real part
//   in_img     bit-reversed-order imaginary part
//   in_valid   input sample qualifier
//   in_first   marks input sample index 0
//   out_real   natural-order real part
//   out_img    natural-order imaginary part
//   out_valid  output sample qualifier
//   out_first  high with output bin 0
//   out_last   high with output bin L-1
//   frame_drop one-cycle pulse when a partial frame is discarded
// master = upstream driver / downstream sink, slave = the reorder buffer.
interface fft_reorder_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        cfg;
   logic [DATA_W-1:0] in_real;
   logic [DATA_W-1:0] in_img;
   logic              in_valid;
   logic              in_first;
   logic [DATA_W-1:0] out_real;
   logic [DATA_W-1:0] out_img;
   logic              out_valid;
   logic              out_first;
   logic              out_last;
   logic              frame_drop;

   modport master (
      output cfg, in_real, in_img, in_valid, in_first,
      input  out_real, out_img, out_valid, out_first, out_last, frame_drop
   );

   modport slave (
      input  cfg, in_real, in_img, in_valid, in_first,
      output out_real, out_img, out_valid, out_first, out_last, frame_drop
   );
endinterface

// File: rtl/fft_reorder.sv
// fft_reorder: output reorder buffer for the radix-2 FFT pipeline. Frames
// arrive in bit-reversed index order and are written at bit-reversed
// addresses into one bank of a ping-pong RAM; a completed bank is then read
// out linearly, giving natural index order with first/last/valid framing.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset
//   bus  fft_reorder_if.slave (cfg, in_*, out_*, frame_drop)
//
// state | meaning
// ------+-------------------------------------------------------------
// WIDLE | write side waiting for in_first
// WFILL | write side filling the write bank, wcnt = next sample index
// RIDLE | read side has no bank to drain
// RBUSY | read side issuing RAM reads at rcnt from the read bank
module fft_reorder #(
   parameter int DATA_W = 32,
   parameter int LOG2N  = 14
) (
   input logic          clk,
   input logic          rst,
   fft_reorder_if.slave bus
);
   localparam int LEN_W = $clog2(LOG2N + 1);
   localparam int DEPTH = 2 ** (LOG2N + 1);
   localparam logic [LOG2N-1:0] ONE = LOG2N'(1);

   typedef enum logic {WIDLE, WFILL} wstate_t;
   typedef enum logic {RIDLE, RBUSY} rstate_t;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [3:0] c);
      if (c == 4'd0) return LEN_W'(1);
      if (int'(c) > LOG2N) return LEN_W'(LOG2N);
      return LEN_W'(c);
   endfunction

   function automatic logic [LOG2N-1:0] last_idx(input logic [LEN_W-1:0] n);
      logic [LOG2N:0] one_hot;
      one_hot = (LOG2N + 1)'(1) << n;
      // n == LOG2N leaves the low bits zero, wrapping to all ones.
      return one_hot[LOG2N-1:0] - ONE;
   endfunction

   // Reverse all LOG2N bits, then shift down so only the low n bits remain
   // reversed in place (the upper bits of x are zero within a frame).
   function automatic logic [LOG2N-1:0] bitrev_len(input logic [LOG2N-1:0] x,
                                                   input logic [LEN_W-1:0] n);
      logic [LOG2N-1:0] r;
      int sh;
      for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
      sh = LOG2N - int'(n);
      return r >> sh;
   endfunction

   logic [2*DATA_W-1:0] mem [DEPTH];

   wstate_t          wstate, wstate_nxt;
   logic [LOG2N-1:0] wcnt, wcnt_nxt;
   logic [LEN_W-1:0] wlen, wlen_nxt;
   logic             wbank, wbank_nxt;
   logic             we;
   logic [LOG2N-1:0] waddr;
   logic             hand;
   logic             drop;

   rstate_t          rstate, rstate_nxt;
   logic [LOG2N-1:0] rcnt, rcnt_nxt;
   logic [LEN_W-1:0] rlen, rlen_nxt;
   logic             rbank, rbank_nxt;
   logic             rd_en;

   logic [DATA_W-1:0] out_real_q, out_img_q;
   logic              out_valid_q, out_first_q, out_last_q, frame_drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate <= WIDLE;
         wcnt   <= '0;
         wlen   <= '0;
         wbank  <= 1'b0;
         rstate <= RIDLE;
         rcnt   <= '0;
         rlen   <= '0;
         rbank  <= 1'b0;
      end else begin
         wstate <= wstate_nxt;
         wcnt   <= wcnt_nxt;
         wlen   <= wlen_nxt;
         wbank  <= wbank_nxt;
         rstate <= rstate_nxt;
         rcnt   <= rcnt_nxt;
         rlen   <= rlen_nxt;
         rbank  <= rbank_nxt;
      end
   end

   always_comb begin
      wstate_nxt = wstate;
      wcnt_nxt   = wcnt;
      wlen_nxt   = wlen;
      wbank_nxt  = wbank;
      we         = 1'b0;
      waddr      = '0;
      hand       = 1'b0;
      drop       = 1'b0;
      case (wstate)
         WIDLE: begin
            if (bus.in_valid && bus.in_first) begin
               we         = 1'b1;
               wlen_nxt   = clamp_len(bus.cfg);
               wcnt_nxt   = ONE;
               wstate_nxt = WFILL;
            end
         end
         WFILL: begin
            if (bus.in_valid) begin
               we = 1'b1;
               if (bus.in_first) begin
                  // Restart in the same bank; the partial frame is overwritten.
                  drop     = 1'b1;
                  wlen_nxt = clamp_len(bus.cfg);
                  wcnt_nxt = ONE;
               end else begin
                  waddr = bitrev_len(wcnt, wlen);
                  if (wcnt == last_idx(wlen)) begin
                     hand       = 1'b1;
                     wbank_nxt  = ~wbank;
                     wcnt_nxt   = '0;
                     wstate_nxt = WIDLE;
                  end else begin
                     wcnt_nxt = wcnt + ONE;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      rstate_nxt = rstate;
      rcnt_nxt   = rcnt;
      rlen_nxt   = rlen;
      rbank_nxt  = rbank;
      rd_en      = 1'b0;
      case (rstate)
         RIDLE: ;
         RBUSY: begin
            rd_en    = 1'b1;
            rcnt_nxt = rcnt + ONE;
            if (rcnt == last_idx(rlen)) begin
               rstate_nxt = RIDLE;
               rcnt_nxt   = '0;
            end
         end
      endcase
      // A handoff can coincide with the final read of the previous bank
      // under back-to-back input; it always wins so the read never stalls.
      if (hand) begin
         rstate_nxt = RBUSY;
         rcnt_nxt   = '0;
         rlen_nxt   = wlen;
         rbank_nxt  = wbank;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[{wbank, waddr}] <= {bus.in_real, bus.in_img};
   end

   // The RAM read register doubles as the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_real_q   <= '0;
         out_img_q    <= '0;
         out_valid_q  <= 1'b0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         out_valid_q  <= rd_en;
         out_first_q  <= rd_en && (rcnt == '0);
         out_last_q   <= rd_en && (rcnt == last_idx(rlen));
         frame_drop_q <= drop;
         if (rd_en) {out_real_q, out_img_q} <= mem[{rbank, rcnt}];
      end
   end

   assign bus.out_real   = out_real_q;
   assign bus.out_img    = out_img_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_first  = out_first_q;
   assign bus.out_last   = out_last_q;
   assign bus.frame_drop = frame_drop_q;
endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   fft_reorder_if #(.DATA_W(32)) bus();

   fft_reorder #(.DATA_W(32), .LOG2N(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] re;
      logic [31:0] im;
      logic        first;
      logic        last;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;
   int out_cnt = 0, first_cnt = 0, last_cnt = 0, drop_cnt = 0, drop_cyc = -1;

   function automatic int brev(input int n, input int len);
      int r = 0;
      for (int i = 0; i < len; i++) if (n[i]) r |= 1 << (len - 1 - i);
      return r;
   endfunction

   function automatic int eff_len(input int c);
      if (c == 0) return 1;
      if (c > 14) return 14;
      return c;
   endfunction

   // Scoreboard consumer: every valid output must match the head entry,
   // including the cycle it is expected in.
   always @(negedge clk) begin
      exp_t e;
      if (bus.frame_drop) begin
         drop_cnt++;
         drop_cyc = cyc;
      end
      if (bus.out_valid) begin
         out_cnt++;
         if (bus.out_first) first_cnt++;
         if (bus.out_last) last_cnt++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output got re=%h cyc=%0d required no output", bus.out_real, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.out_real !== e.re || bus.out_img !== e.im || bus.out_first !== e.first ||
                bus.out_last !== e.last || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL out_sample got re=%h im=%h f=%b l=%b cyc=%0d required re=%h im=%h f=%b l=%b cyc=%0d",
                        bus.out_real, bus.out_img, bus.out_first, bus.out_last, cyc,
                        e.re, e.im, e.first, e.last, e.cyc);
            end
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
   endtask

   task automatic send_frame(input int cfg_v, input int base, input bit gaps,
                             output int t_first, output int t_last);
      int len, l;
      logic [31:0] v;
      len = eff_len(cfg_v);
      l = 1 << len;
      t_first = 0;
      t_last = 0;
      for (int n = 0; n < l; n++) begin
         if (gaps && n > 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_first = 1'b0;
         end
         @(negedge clk);
         v = 32'(base + brev(n, len));
         bus.cfg      = 4'(cfg_v);
         bus.in_valid = 1'b1;
         bus.in_first = (n == 0);
         bus.in_real  = v;
         bus.in_img   = ~v;
         if (n == 0) t_first = cyc;
      end
      t_last = cyc;
      for (int k = 0; k < l; k++)
         sb.push_back('{32'(base + k), ~32'(base + k), (k == 0), (k == l - 1), t_last + 2 + k});
   endtask

   task automatic wait_drain(input int budget, output bit done);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      done = (sb.size() == 0);
      sb.delete();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.cfg = 4'd0; bus.in_valid = 1'b0; bus.in_first = 1'b0;
      bus.in_real = '0; bus.in_img = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
      n_cmp++; if (bus.out_first !== 1'b0) begin n_bad++; $display("FAIL reset_out_first got %b required 0", bus.out_first); end
      n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b required 0", bus.out_last); end
      n_cmp++; if (bus.frame_drop !== 1'b0) begin n_bad++; $display("FAIL reset_frame_drop got %b required 0", bus.frame_drop); end
      n_cmp++; if (bus.out_real !== 32'd0) begin n_bad++; $display("FAIL reset_out_real got %h required 0", bus.out_real); end
      n_cmp++; if (bus.out_img !== 32'd0) begin n_bad++; $display("FAIL reset_out_img got %h required 0", bus.out_img); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int tf, tl, d0, o0;
      bit done;
      d0 = drop_cnt; o0 = out_cnt;
      send_frame(3, 0, 1'b0, tf, tl);
      idle();
      wait_drain(40, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL single_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 8) begin n_bad++; $display("FAIL single_count got %0d required 8", out_cnt - o0); end
      n_cmp++; if (drop_cnt != d0) begin n_bad++; $display("FAIL single_drop got %0d required 0", drop_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      int tf, tl, o0, f0, l0, d0;
      bit done;
      o0 = out_cnt; f0 = first_cnt; l0 = last_cnt; d0 = drop_cnt;
      send_frame(4, 100, 1'b0, tf, tl);
      send_frame(4, 200, 1'b0, tf, tl);
      send_frame(4, 300, 1'b0, tf, tl);
      idle();
      wait_drain(80, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL b2b_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 48) begin n_bad++; $display("FAIL b2b_count got %0d required 48", out_cnt - o0); end
      n_cmp++; if (first_cnt - f0 != 3) begin n_bad++; $display("FAIL b2b_firsts got %0d required 3", first_cnt - f0); end
      n_cmp++; if (last_cnt - l0 != 3) begin n_bad++; $display("FAIL b2b_lasts got %0d required 3", last_cnt - l0); end
      n_cmp++; if (drop_cnt != d0) begin n_bad++; $display("FAIL b2b_drop got %0d required 0", drop_cnt - d0); end
   endtask

   task automatic test_gaps();
      int tf, tl, o0;
      bit done;
      o0 = out_cnt;
      // Valid samples without in_first while idle must be ignored.
      repeat (2) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_first = 1'b0; bus.in_real = 32'hdead; bus.in_img = 32'hbeef;
      end
      idle();
      send_frame(3, 1000, 1'b1, tf, tl);
      idle();
      wait_drain(40, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL gaps_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 8) begin n_bad++; $display("FAIL gaps_count got %0d required 8", out_cnt - o0); end
   endtask

   task automatic test_restart();
      int tf, tl, o0, d0;
      bit done;
      o0 = out_cnt; d0 = drop_cnt;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         bus.cfg = 4'd4; bus.in_valid = 1'b1; bus.in_first = (n == 0);
         bus.in_real = 32'(900 + n); bus.in_img = 32'(950 + n);
      end
      send_frame(3, 700, 1'b0, tf, tl);
      idle();
      wait_drain(40, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL restart_timeout got pending required drained"); end
      n_cmp++; if (drop_cnt - d0 != 1) begin n_bad++; $display("FAIL restart_drop_count got %0d required 1", drop_cnt - d0); end
      n_cmp++; if (drop_cyc != tf + 1) begin n_bad++; $display("FAIL restart_drop_cycle got %0d required %0d", drop_cyc, tf + 1); end
      n_cmp++; if (out_cnt - o0 != 8) begin n_bad++; $display("FAIL restart_count got %0d required 8", out_cnt - o0); end
   endtask

   task automatic test_min_clamp();
      int tf, tl, o0, f0, l0;
      bit done;
      o0 = out_cnt; f0 = first_cnt; l0 = last_cnt;
      send_frame(0, 800, 1'b0, tf, tl);
      idle();
      wait_drain(20, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL min_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 2) begin n_bad++; $display("FAIL min_count got %0d required 2", out_cnt - o0); end
      n_cmp++; if (first_cnt - f0 != 1 || last_cnt - l0 != 1) begin
         n_bad++; $display("FAIL min_framing got first=%0d last=%0d required 1 1", first_cnt - f0, last_cnt - l0);
      end
   endtask

   task automatic test_max();
      int tf, tl, o0, l0;
      bit done;
      o0 = out_cnt; l0 = last_cnt;
      send_frame(15, 32'h10000, 1'b0, tf, tl);
      idle();
      wait_drain(16500, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL max_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 16384) begin n_bad++; $display("FAIL max_count got %0d required 16384", out_cnt - o0); end
      n_cmp++; if (last_cnt - l0 != 1) begin n_bad++; $display("FAIL max_last got %0d required 1", last_cnt - l0); end
   endtask

   task automatic test_reset_mid_read();
      int tf, tl, o0;
      bit done;
      send_frame(3, 500, 1'b0, tf, tl);
      idle();
      while (cyc < tl + 5) @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midread_valid got %b required 0", bus.out_valid); end
      rst = 1'b0;
      o0 = out_cnt;
      repeat (12) @(negedge clk);
      n_cmp++; if (out_cnt != o0) begin n_bad++; $display("FAIL midread_quiet got %0d required 0", out_cnt - o0); end
      send_frame(3, 600, 1'b0, tf, tl);
      idle();
      wait_drain(40, done);
      n_cmp++; if (!done) begin n_bad++; $display("FAIL midread_timeout got pending required drained"); end
      n_cmp++; if (out_cnt - o0 != 8) begin n_bad++; $display("FAIL midread_count got %0d required 8", out_cnt - o0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gaps();
      test_restart();
      test_min_clamp();
      test_reset_mid_read();
      test_max();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
